// File: rtl/lutram_dp.sv
// -----------------------------------------------------------------------------
// lutram_dp
// Distributed (LUT) RAM, WIDTH x 2**ADDR_BITS. It has one synchronous write port
// and one asynchronous read port. The array has no reset.
// This is the multi-bit form of the single-bit LUT RAM cell. It is also
// suitable for small register files.
//
// Ports:
//   clock  : write clock (rising edge)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address (combinational read)
//   rdata  : data at raddr
// -----------------------------------------------------------------------------
module lutram_dp #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read path is asynchronous. New data is visible in the same cycle that
  // raddr changes.
  assign rdata = mem[raddr];

endmodule

// File: rtl/lutram_fifo.sv
// -----------------------------------------------------------------------------
// lutram_fifo
// Synchronous first-word-fall-through FIFO built on distributed RAM.
// Typical uses are the store buffer and the instruction prefetch queue.
// It provides an occupancy count, an almost-full threshold, sticky
// overflow/underflow flags and a synchronous clear.
//
// Handshake semantics (push side and pop side):
//   - A push is accepted when push && (!full || pop). The data is written at
//     wrPtr and wrPtr increments. When push && full && !pop, the push is
//     rejected and overflowError sets.
//   - A pop is accepted when pop && !empty. The head entry is on popData before
//     the edge and rdPtr increments. When pop && empty, the pop is rejected and
//     underflowError sets.
//   - clear overrides push and pop. Nothing is accepted and nothing is flagged.
//   - full, empty and almostFull come only from the registered fill count.
//     They have no combinational path from push or pop.
//
// Ports:
//   clock, reset     : clock; asynchronous active-high reset
//   clear            : synchronous flush (pointers, count, error flags)
//   push, pushData   : write request and data
//   pop              : consume head entry
//   popData          : head entry, valid while !empty
//   full, empty      : fillLevel == DEPTH / fillLevel == 0
//   almostFull       : fillLevel >= ALMOST_FULL_LEVEL
//   fillLevel        : stored entries, 0..DEPTH
//   overflowError    : sticky, a push was rejected
//   underflowError   : sticky, a pop was rejected
// -----------------------------------------------------------------------------
module lutram_fifo #(
  parameter int WIDTH             = 32,
  parameter int ADDR_BITS         = 4,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               push,
  input  logic [WIDTH-1:0]   pushData,
  input  logic               pop,
  output logic [WIDTH-1:0]   popData,
  output logic               full,
  output logic               empty,
  output logic               almostFull,
  output logic [ADDR_BITS:0] fillLevel,
  output logic               overflowError,
  output logic               underflowError
);

  localparam int                 DEPTH    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_L  = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] AF_LEVEL = ALMOST_FULL_LEVEL[ADDR_BITS:0];

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   fill_q;
  logic                 overflow_q;
  logic                 underflow_q;

  logic                 push_ok;
  logic                 pop_ok;
  logic                 push_rej;
  logic                 pop_rej;
  logic [ADDR_BITS:0]   fill_d;

  // The status flags are decoded from the registered count only.
  assign full       = (fill_q == DEPTH_L);
  assign empty      = (fill_q == '0);
  assign almostFull = (fill_q >= AF_LEVEL);
  assign fillLevel  = fill_q;

  assign overflowError  = overflow_q;
  assign underflowError = underflow_q;

  always_comb begin
    push_ok  = 1'b0;
    pop_ok   = 1'b0;
    push_rej = 1'b0;
    pop_rej  = 1'b0;
    fill_d   = fill_q;
    if (!clear) begin
      // A simultaneous pop frees the head slot, so a push at full is still
      // accepted. The old head is read before the edge and the slot is then
      // rewritten (wrPtr == rdPtr).
      push_ok  = push && (!full || pop);
      pop_ok   = pop && !empty;
      push_rej = push && full && !pop;
      pop_rej  = pop && empty;
      case ({push_ok, pop_ok})
        2'b10:   fill_d = fill_q + 1'b1;
        2'b01:   fill_d = fill_q - 1'b1;
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // The pointers are exactly ADDR_BITS wide, so they wrap modulo DEPTH
      // without any extra logic.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      fill_q <= fill_d;
      if (push_rej) overflow_q  <= 1'b1;
      if (pop_rej)  underflow_q <= 1'b1;
    end
  end

  lutram_dp #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clock (clock),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (pushData),
    .raddr (rd_ptr),
    .rdata (popData)
  );

  // DEPTH is used only to document the relationship between DEPTH and
  // DEPTH_L. The tie-off below keeps it referenced.
  logic unused_depth;
  assign unused_depth = (DEPTH == 0);

endmodule

// File: tb/tb_lutram_fifo.sv
module tb_lutram_fifo;

  localparam int WIDTH = 32;
  localparam int AB    = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            clear;
  logic            push;
  logic [WIDTH-1:0] pushData;
  logic            pop;
  logic [WIDTH-1:0] popData;
  logic            full;
  logic            empty;
  logic            almostFull;
  logic [AB:0]     fillLevel;
  logic            overflowError;
  logic            underflowError;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  lutram_fifo #(
    .WIDTH             (WIDTH),
    .ADDR_BITS         (AB),
    .ALMOST_FULL_LEVEL (12)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .clear          (clear),
    .push           (push),
    .pushData       (pushData),
    .pop            (pop),
    .popData        (popData),
    .full           (full),
    .empty          (empty),
    .almostFull     (almostFull),
    .fillLevel      (fillLevel),
    .overflowError  (overflowError),
    .underflowError (underflowError)
  );

  // Clock and reset block
  always #5 clock = ~clock;

  // Driver: inputs are applied at the falling edge and held through one rising
  // edge. The task returns at the next falling edge with push/pop idle, so
  // outputs are sampled away from the active edge.
  task automatic drive(input logic p, input logic [WIDTH-1:0] d, input logic q, input logic c);
    push = p; pushData = d; pop = q; clear = c;
    @(posedge clock);
    @(negedge clock);
    push = 1'b0; pop = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; pushData = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({empty, full, almostFull, overflowError, underflowError} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got e/f/af/ov/un=%b expected 10000",
               {empty, full, almostFull, overflowError, underflowError});
    end
    checks++;
    if (fillLevel !== 5'd0) begin
      errors++;
      $display("FAIL reset_fill: got %0d expected 0", fillLevel);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h1000 + i, 1'b0, 1'b0);
      checks++;
      if (fillLevel !== 5'(i + 1) || almostFull !== (i + 1 >= 12) || full !== (i + 1 == 16)) begin
        errors++;
        $display("FAIL fill_push%0d: got fill=%0d af=%b full=%b expected fill=%0d af=%b full=%b",
                 i, fillLevel, almostFull, full, i + 1, (i + 1 >= 12), (i + 1 == 16));
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (popData !== 32'h1000 + i) begin
        errors++;
        $display("FAIL drain_data%0d: got %h expected %h", i, popData, 32'h1000 + i);
      end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (empty !== 1'b1 || fillLevel !== 5'd0 || overflowError !== 1'b0 || underflowError !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: got empty=%b fill=%0d ov=%b un=%b expected 1 0 0 0",
               empty, fillLevel, overflowError, underflowError);
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] exp;
    int peak = 0;
    // The first block moves both pointers to 10. The second block of 12
    // entries then crosses 15 -> 0.
    for (int blk = 0; blk < 2; blk++) begin
      int n = (blk == 0) ? 10 : 12;
      for (int i = 0; i < n; i++) begin
        drive(1'b1, 32'h2000 + blk * 32'h100 + i, 1'b0, 1'b0);
        exp_q.push_back(32'h2000 + blk * 32'h100 + i);
        if (int'(fillLevel) > peak) peak = int'(fillLevel);
      end
      for (int i = 0; i < n; i++) begin
        exp = exp_q.pop_front();
        checks++;
        if (popData !== exp) begin
          errors++;
          $display("FAIL wrap_data b%0d i%0d: got %h expected %h", blk, i, popData, exp);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
      end
    end
    checks++;
    if (peak != 12 || empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_peak: got peak=%0d empty=%b expected 12 1", peak, empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) drive(1'b1, 32'h4000 + i, 1'b0, 1'b0);
    drive(1'b1, 32'h0000DEAD, 1'b0, 1'b0);
    checks++;
    if (fillLevel !== 5'd16 || overflowError !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: got fill=%0d ov=%b full=%b expected 16 1 1",
               fillLevel, overflowError, full);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (popData !== 32'h4000 + i) begin
        errors++;
        $display("FAIL overflow_data%0d: got %h expected %h", i, popData, 32'h4000 + i);
      end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (overflowError !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got ov=%b empty=%b expected 1 1", overflowError, empty);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (overflowError !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got ov=%b expected 0", overflowError);
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (underflowError !== 1'b1 || fillLevel !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_flag: got un=%b fill=%0d empty=%b expected 1 0 1",
               underflowError, fillLevel, empty);
    end
    drive(1'b1, 32'h000000A5, 1'b1, 1'b0);
    checks++;
    if (fillLevel !== 5'd1 || popData !== 32'h000000A5 || empty !== 1'b0 || underflowError !== 1'b1) begin
      errors++;
      $display("FAIL empty_push_pop: got fill=%0d data=%h empty=%b un=%b expected 1 000000a5 0 1",
               fillLevel, popData, empty, underflowError);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (underflowError !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_clear: got un=%b empty=%b expected 0 1", underflowError, empty);
    end
  endtask

  task automatic test_full_push_pop();
    logic [WIDTH-1:0] exp;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h5000 + i, 1'b0, 1'b0);
      exp_q.push_back(32'h5000 + i);
    end
    exp = exp_q.pop_front();
    checks++;
    if (popData !== exp) begin
      errors++;
      $display("FAIL full_pp_head: got %h expected %h", popData, exp);
    end
    drive(1'b1, 32'h0000BEEF, 1'b1, 1'b0);
    exp_q.push_back(32'h0000BEEF);
    checks++;
    if (fillLevel !== 5'd16 || full !== 1'b1 || overflowError !== 1'b0) begin
      errors++;
      $display("FAIL full_pp_level: got fill=%0d full=%b ov=%b expected 16 1 0",
               fillLevel, full, overflowError);
    end
    for (int i = 0; i < 16; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (popData !== exp) begin
        errors++;
        $display("FAIL full_pp_data%0d: got %h expected %h", i, popData, exp);
      end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (empty !== 1'b1 || underflowError !== 1'b0) begin
      errors++;
      $display("FAIL full_pp_end: got empty=%b un=%b expected 1 0", empty, underflowError);
    end
  endtask

  task automatic test_clear();
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b1, 32'h6000 + i, 1'b0, 1'b0);
    drive(1'b1, 32'h0000DEAD, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (fillLevel !== 5'd5 || overflowError !== 1'b1 || underflowError !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: got fill=%0d ov=%b un=%b expected 5 1 1",
               fillLevel, overflowError, underflowError);
    end
    drive(1'b1, 32'h00007777, 1'b0, 1'b1);
    checks++;
    if (fillLevel !== 5'd0 || empty !== 1'b1 || overflowError !== 1'b0 || underflowError !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: got fill=%0d empty=%b ov=%b un=%b expected 0 1 0 0",
               fillLevel, empty, overflowError, underflowError);
    end
    drive(1'b1, 32'h00008888, 1'b0, 1'b0);
    checks++;
    if (popData !== 32'h00008888 || fillLevel !== 5'd1) begin
      errors++;
      $display("FAIL clear_after: got data=%h fill=%0d expected 00008888 1", popData, fillLevel);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) drive(1'b1, 32'h9000 + i, 1'b0, 1'b0);
    checks++;
    if (almostFull !== 1'b1 || underflowError !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: got af=%b un=%b expected 1 1", almostFull, underflowError);
    end
    // Reset is raised halfway between a falling and a rising edge. It must
    // take effect without any clock edge.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({empty, full, almostFull, overflowError, underflowError} !== 5'b10000 || fillLevel !== 5'd0) begin
      errors++;
      $display("FAIL areset_now: got e/f/af/ov/un=%b fill=%0d expected 10000 0",
               {empty, full, almostFull, overflowError, underflowError}, fillLevel);
    end
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 32'h0000ABCD, 1'b0, 1'b0);
    checks++;
    if (popData !== 32'h0000ABCD || fillLevel !== 5'd1) begin
      errors++;
      $display("FAIL areset_after: got data=%h fill=%0d expected 0000abcd 1", popData, fillLevel);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_overflow();
    test_underflow();
    test_full_push_pop();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lutram_fifo.md
Name: lutram_fifo

Overview:
- Parametrised synchronous FIFO built on distributed (LUT) RAM: one write port, asynchronous read, configurable width and depth.
- First-word-fall-through: the head entry is always visible on popData while not empty.
- Adds occupancy count, almost-full threshold, sticky overflow/underflow error flags and a synchronous clear.
- Used as the small elastic buffer between or1420 pipeline/bus stages, e.g. store buffer and instruction prefetch queue.

Parameters:
- WIDTH, 32, data bits per entry (>=1).
- ADDR_BITS, 4, log2 of depth; DEPTH = 2**ADDR_BITS entries (>=1).
- ALMOST_FULL_LEVEL, 12, almostFull asserts when fillLevel >= this value (1..DEPTH).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush: empties the FIFO and clears the error flags.
- push  input  1  write request for pushData.
- pushData  input  WIDTH  entry to be written.
- pop  input  1  consume the head entry.
- popData  output  WIDTH  head entry (FWFT); valid only while empty==0.
- full  output  1  fillLevel == DEPTH.
- empty  output  1  fillLevel == 0.
- almostFull  output  1  fillLevel >= ALMOST_FULL_LEVEL.
- fillLevel  output  ADDR_BITS+1  number of stored entries, 0..DEPTH.
- overflowError  output  1  sticky: a push was rejected.
- underflowError  output  1  sticky: a pop was rejected.

Behaviour:
- Reset (asynchronous): wrPtr=0, rdPtr=0, fillLevel=0, empty=1, full=0, almostFull=0, overflowError=0, underflowError=0. Storage array is not reset; popData is undefined while empty.
- Priority: reset > clear > push/pop.
- Clear: on the next edge, pointers and fillLevel go to 0 and both error flags go to 0. Push/pop in the same cycle are ignored and flag nothing.
- Storage: DEPTH x WIDTH array.
  - Write at wrPtr on the edge when the push is accepted.
  - Read is combinational at rdPtr, so popData changes in the same cycle rdPtr moves.
- Pointers: ADDR_BITS wide, increment modulo DEPTH; wrap from DEPTH-1 to 0 with no gap.
- Accepted push: push && (!full || pop). Data is written, wrPtr+1.
- Accepted pop: pop && !empty. rdPtr+1.
- Rejected push: push && full && !pop. No state change except overflowError<=1.
- Rejected pop: pop && empty. No state change except underflowError<=1.
- fillLevel update, per edge:
  - +1 if only the push is accepted.
  - -1 if only the pop is accepted.
  - Unchanged if both or neither are accepted.
- Full with push && pop: both accepted, fillLevel stays DEPTH. The old head is read before the edge, then the new data is written into the freed slot (wrPtr==rdPtr).
- Empty with push && pop: push accepted, pop rejected; underflowError<=1, fillLevel becomes 1.
- Write-to-read latency: data pushed at edge N appears on popData after edge N when the FIFO was empty (empty deasserts after the same edge).
- Flags: full, empty and almostFull are registered or derived from registered fillLevel. They have no combinational path from push/pop.
- Error flags: remain 1 until clear or reset.
- DEPTH==1 (ADDR_BITS=0): not supported; requires ADDR_BITS>=1.

Decomposition:
- No shared package; DEPTH is a localparam derived from ADDR_BITS.
- One sub-module, lutram_dp: parametrised WIDTH x 2**ADDR_BITS distributed RAM with write enable, write address and asynchronous read address/data, no reset. It is the generalised multi-bit form of the existing single-bit LUT RAM cell and is reusable for register files.
- The FIFO top holds pointers, count, flags and the accept logic.

Test Plan (defaults: WIDTH=32, DEPTH=16, ALMOST_FULL_LEVEL=12):
- Fill/drain: push 16 words 0x1000..0x100F, then pop 16.
  - Full after the 16th push; almostFull from fillLevel=12.
  - popData sequence 0x1000..0x100F in order; empty=1 at the end; no error flags.
- Wrap-around: push 10, pop 10, push 12, pop 12 (pointers cross 15->0). Data stays in order and fillLevel peaks at 12.
- Overflow: at full, push 0xDEAD with pop=0.
  - fillLevel stays 16 and overflowError=1.
  - The next pops return the original data, with no 0xDEAD.
- Underflow and empty corner:
  - Empty, pop alone -> underflowError=1, fillLevel=0.
  - Empty, push 0xA5 together with pop -> fillLevel=1, popData=0xA5.
- Full with simultaneous push 0xBEEF and pop: popData before the edge is the old head, fillLevel stays 16, and 0xBEEF emerges as the 16th subsequent pop.
- Clear and reset mid-operation:
  - With 5 entries and both error flags set, assert clear together with push -> fillLevel=0, empty=1, flags=0, push ignored.
  - Assert reset asynchronously between edges -> all outputs return to reset values immediately.
